wb_unit: RTL

- Write-back (Wr) stage of the 5-stage pipeline: the MEM/WB pipeline register plus the write-back datapath.
- Produces the write-back bus consumed by the register-file write port in the Reg/Dec stage: busW, Rw_Wr, RegWr_Wr, OverFlow_Wr, Jal_Wr.
- Also provides Wr-stage forwarding-hit flags to the Ex stage.

---
 rtl/wb_unit_pkg.sv | 36 +++
 rtl/wb_load_align.sv | 43 ++++
 rtl/wb_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/wb_unit_pkg.sv
// ============================================================================
// Module  : wb_unit_pkg
// Purpose : Shared constants, load-width encodings and the MEM/WB control
//           record used by the write-back stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_unit_pkg;

   localparam int WB_DW       = 32;
   localparam int WB_AW       = 5;
   localparam int WB_LINK_REG = 31;

   typedef enum logic [1:0] {
      LB_WORD  = 2'b00,
      LB_SBYTE = 2'b01,
      LB_UBYTE = 2'b10,
      LB_RSVD  = 2'b11
   } load_byte_e;

   typedef struct packed {
      logic       valid;
      logic       regwr;
      logic       memtoreg;
      logic       ovf;
      logic       jal;
      load_byte_e lb;
   } wb_ctl_t;

   localparam wb_ctl_t WB_CTL_NOP = '{valid: 1'b0, regwr: 1'b0, memtoreg: 1'b0,
                                      ovf: 1'b0, jal: 1'b0, lb: LB_WORD};

endpackage

`default_nettype wire

// File: rtl/wb_load_align.sv
// ============================================================================
// Module  : wb_load_align
// Purpose : Big-endian byte select and sign/zero extension of a loaded word.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_load_align
   import wb_unit_pkg::*;
#(
   parameter int DW = WB_DW
) (
   input  logic [DW-1:0] dout_i,
   input  logic [1:0]    addr_i,
   input  load_byte_e    lb_i,
   output logic [DW-1:0] data_o
);

   logic [7:0] byte_w;

   // Byte 0 is the most significant byte of the word.
   always_comb begin
      byte_w = 8'h00;
      case (addr_i)
         2'd0:    byte_w = dout_i[31:24];
         2'd1:    byte_w = dout_i[23:16];
         2'd2:    byte_w = dout_i[15:8];
         default: byte_w = dout_i[7:0];
      endcase
   end

   always_comb begin
      data_o = dout_i;
      case (lb_i)
         LB_SBYTE: data_o = {{(DW-8){byte_w[7]}}, byte_w};
         LB_UBYTE: data_o = {{(DW-8){1'b0}}, byte_w};
         default:  data_o = dout_i;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/wb_unit.sv
// ============================================================================
// Module  : wb_unit
// Purpose : MEM/WB pipeline register, write-back datapath and Wr-stage
//           forwarding flags. Optional retire counter: WB_RETIRE_CNT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_unit
   import wb_unit_pkg::*;
#(
   parameter int DW       = WB_DW,
   parameter int AW       = WB_AW,
   parameter int LINK_REG = WB_LINK_REG,
   parameter int LINK_OFS = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic          valid_Mem,
   input  logic [DW-1:0] ALUout_Mem,
   input  logic [DW-1:0] Dout_Mem,
   input  logic [DW-1:0] PC_Addr_Mem,
   input  logic [AW-1:0] Rw_Mem,
   input  logic          RegWr_Mem,
   input  logic          MemToReg_Mem,
   input  logic          OverFlow_Mem,
   input  logic          Jal_Mem,
   input  logic [1:0]    LoadByte_Mem,
   input  logic [AW-1:0] Rs_Ex,
   input  logic [AW-1:0] Rt_Ex,
   output logic [DW-1:0] busW,
   output logic [AW-1:0] Rw_Wr,
   output logic          RegWr_Wr,
   output logic          OverFlow_Wr,
   output logic          Jal_Wr,
   output logic          valid_Wr,
   output logic          fwdA_Wr,
`ifdef WB_RETIRE_CNT_EN
   output logic [DW-1:0] retire_cnt,
`endif
   output logic          fwdB_Wr
);

   wb_ctl_t       ctl_q,  ctl_d;
   logic [DW-1:0] alu_q,  alu_d;
   logic [DW-1:0] dout_q, dout_d;
   logic [DW-1:0] pc_q,   pc_d;
   logic [AW-1:0] rw_q,   rw_d;
   logic [DW-1:0] load_w;
   logic          fwd_ok_w;

   // Priority: flush over stall over normal capture (reset handled in the flop).
   always_comb begin
      ctl_d  = ctl_q;
      alu_d  = alu_q;
      dout_d = dout_q;
      pc_d   = pc_q;
      rw_d   = rw_q;
      if (flush) begin
         ctl_d  = WB_CTL_NOP;
         alu_d  = '0;
         dout_d = '0;
         pc_d   = '0;
         rw_d   = '0;
      end else if (!stall) begin
         ctl_d.valid    = valid_Mem;
         ctl_d.regwr    = RegWr_Mem;
         ctl_d.memtoreg = MemToReg_Mem;
         ctl_d.ovf      = OverFlow_Mem;
         ctl_d.jal      = Jal_Mem;
         ctl_d.lb       = load_byte_e'(LoadByte_Mem);
         alu_d          = ALUout_Mem;
         dout_d         = Dout_Mem;
         pc_d           = PC_Addr_Mem;
         rw_d           = Rw_Mem;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctl_q  <= WB_CTL_NOP;
         alu_q  <= '0;
         dout_q <= '0;
         pc_q   <= '0;
         rw_q   <= '0;
      end else begin
         ctl_q  <= ctl_d;
         alu_q  <= alu_d;
         dout_q <= dout_d;
         pc_q   <= pc_d;
         rw_q   <= rw_d;
      end
   end

   wb_load_align #(.DW(DW)) u_align (
      .dout_i (dout_q),
      .addr_i (alu_q[1:0]),
      .lb_i   (ctl_q.lb),
      .data_o (load_w)
   );

   always_comb begin
      if (ctl_q.jal)
         busW = pc_q + DW'(LINK_OFS);
      else if (!ctl_q.memtoreg)
         busW = alu_q;
      else
         busW = load_w;
   end

   assign Rw_Wr       = ctl_q.jal ? AW'(LINK_REG) : rw_q;
   assign valid_Wr    = ctl_q.valid;
   // A jal always writes its link register, whatever RegWr said upstream.
   assign RegWr_Wr    = ctl_q.valid & (ctl_q.regwr | ctl_q.jal);
   assign OverFlow_Wr = ctl_q.valid & ctl_q.ovf;
   assign Jal_Wr      = ctl_q.valid & ctl_q.jal;

   assign fwd_ok_w = RegWr_Wr & ~OverFlow_Wr & (Rw_Wr != '0);
   assign fwdA_Wr  = fwd_ok_w & (Rw_Wr == Rs_Ex);
   assign fwdB_Wr  = fwd_ok_w & (Rw_Wr == Rt_Ex);

`ifdef WB_RETIRE_CNT_EN
   logic [DW-1:0] retire_q;

   always_ff @(posedge clk) begin
      if (rst)
         retire_q <= '0;
      else if (ctl_q.valid && !stall)
         retire_q <= retire_q + 1'b1;
   end

   assign retire_cnt = retire_q;
`endif

endmodule

`default_nettype wire
